// File: rtl/fusion_fetch_pkg.sv
// Shared types and constants for the fetch sequencer and its entry FIFO.
package fusion_fetch_pkg;

  localparam logic [31:0] INSN_NOP = 32'h0000_0000;
  localparam int          ENTRY_W  = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_REQ   = 2'b01,
    S_DRAIN = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits are forced to zero.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, insn} entries between the memory side and decode.
module fetch_fifo
  import fusion_fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = ENTRY_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign level     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Occupancy update; a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage and pointer registers; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(0);
      end
    end else if (flush) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

endmodule

// File: rtl/fetch_sequencer_32.sv
// Instruction fetch controller: req/ack memory fetch into a FIFO, one instruction
// per clock toward decode_32, with flush-and-restart on downstream redirects.
module fetch_sequencer_32
  import fusion_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          INSN_STEP  = 4,
  localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             reset_in,
  output logic             imem_req_out,
  output logic [31:0]      imem_addr_out,
  input  logic             imem_ack_in,
  input  logic [31:0]      imem_data_in,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [31:0]      redirect_addr_in,
  output logic [31:0]      insn_out,
  output logic [31:0]      insn_pc_out,
  output logic             insn_valid_out,
  output logic [LVL_W-1:0] fifo_level_out
);

  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  fetch_pc_r;
  logic [31:0]  pc_nxt_s;
  logic         req_r;
  logic         req_nxt_s;
  logic [31:0]  addr_r;
  logic [31:0]  addr_nxt_s;
  logic [31:0]  insn_r;
  logic [31:0]  insn_pc_r;
  logic         valid_r;

  logic [31:0]  target_s;
  logic         push_s;
  logic         pop_s;
  logic         space_idle_s;
  fetch_entry_t push_entry_s;
  fetch_entry_t head_s;
  logic [LVL_W-1:0] fifo_level_s;
  logic [LVL_W-1:0] lvl_after_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;

  assign target_s     = align_word(redirect_addr_in);
  assign pop_s        = ~redirect_in & ~stall_in & ~fifo_empty_s;
  assign space_idle_s = ~fifo_full_s | pop_s;
  assign lvl_after_s  = fifo_level_s + LVL_W'(1) - LVL_W'(pop_s);
  assign push_entry_s = '{pc: fetch_pc_r, insn: imem_data_in};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk_in),
    .rst_n     (reset_in),
    .flush     (redirect_in),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .level     (fifo_level_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Fetch FSM next state, request and pc; a redirect overrides the normal flow.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    addr_nxt_s  = addr_r;
    pc_nxt_s    = fetch_pc_r;
    push_s      = 1'b0;
    if (redirect_in) begin
      pc_nxt_s = target_s;
      if (req_r && !imem_ack_in) begin
        // Request is still on the bus: hold it and throw away its response.
        state_nxt_s = S_DRAIN;
      end else begin
        state_nxt_s = S_REQ;
        req_nxt_s   = 1'b1;
        addr_nxt_s  = target_s;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (space_idle_s) begin
            state_nxt_s = S_REQ;
            req_nxt_s   = 1'b1;
            addr_nxt_s  = fetch_pc_r;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_REQ: begin
          if (imem_ack_in) begin
            push_s   = 1'b1;
            pc_nxt_s = fetch_pc_r + 32'(INSN_STEP);
            if (lvl_after_s < LVL_W'(FIFO_DEPTH)) begin
              addr_nxt_s = fetch_pc_r + 32'(INSN_STEP);
            end else begin
              state_nxt_s = S_IDLE;
              req_nxt_s   = 1'b0;
            end
          end else begin
            state_nxt_s = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_ack_in) begin
            state_nxt_s = S_REQ;
            addr_nxt_s  = fetch_pc_r;
          end else begin
            state_nxt_s = S_DRAIN;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
          req_nxt_s   = 1'b0;
          addr_nxt_s  = fetch_pc_r;
        end
      endcase
    end
  end

  // Fetch FSM, pc and memory request registers.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_r    <= S_IDLE;
      fetch_pc_r <= RESET_PC_A;
      req_r      <= 1'b0;
      addr_r     <= RESET_PC_A;
    end else begin
      state_r    <= state_nxt_s;
      fetch_pc_r <= pc_nxt_s;
      req_r      <= req_nxt_s;
      addr_r     <= addr_nxt_s;
    end
  end

  // Decode-side output registers: redirect kills, stall holds, otherwise pop or bubble.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      insn_r    <= INSN_NOP;
      insn_pc_r <= 32'h0000_0000;
      valid_r   <= 1'b0;
    end else if (redirect_in) begin
      insn_r  <= INSN_NOP;
      valid_r <= 1'b0;
    end else if (!stall_in) begin
      if (!fifo_empty_s) begin
        insn_r    <= head_s.insn;
        insn_pc_r <= head_s.pc;
        valid_r   <= 1'b1;
      end else begin
        insn_r  <= INSN_NOP;
        valid_r <= 1'b0;
      end
    end
  end

  assign imem_req_out   = req_r;
  assign imem_addr_out  = addr_r;
  assign insn_out       = insn_r;
  assign insn_pc_out    = insn_pc_r;
  assign insn_valid_out = valid_r;
  assign fifo_level_out = fifo_level_s;

endmodule

// File: tb/tb_fetch_sequencer_32.sv
// Directed bench for fetch_sequencer_32: streaming, stall fill/drain, slow ack,
// redirects (drain, full+stall, wrap) and asynchronous reset.
module tb_fetch_sequencer_32;

  logic        clk_in;
  logic        reset_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in;
  logic [31:0] imem_data_in;
  logic        stall_in;
  logic        redirect_in;
  logic [31:0] redirect_addr_in;
  logic [31:0] insn_out;
  logic [31:0] insn_pc_out;
  logic        insn_valid_out;
  logic [2:0]  fifo_level_out;

  int checks;
  int errors;

  fetch_sequencer_32 dut (
    .clk_in           (clk_in),
    .reset_in         (reset_in),
    .imem_req_out     (imem_req_out),
    .imem_addr_out    (imem_addr_out),
    .imem_ack_in      (imem_ack_in),
    .imem_data_in     (imem_data_in),
    .stall_in         (stall_in),
    .redirect_in      (redirect_in),
    .redirect_addr_in (redirect_addr_in),
    .insn_out         (insn_out),
    .insn_pc_out      (insn_pc_out),
    .insn_valid_out   (insn_valid_out),
    .fifo_level_out   (fifo_level_out)
  );

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_00C3;
  endfunction

  assign imem_data_in = mem_word(imem_addr_out);

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_req"},   {31'd0, imem_req_out},   32'd0);
    check_eq({tag, "_addr"},  imem_addr_out,           32'h0000_0000);
    check_eq({tag, "_insn"},  insn_out,                32'h0000_0000);
    check_eq({tag, "_pc"},    insn_pc_out,             32'h0000_0000);
    check_eq({tag, "_valid"}, {31'd0, insn_valid_out}, 32'd0);
    check_eq({tag, "_lvl"},   {29'd0, fifo_level_out}, 32'd0);
  endtask

  task automatic expect_insn(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'd0, insn_valid_out}, 32'd1);
    check_eq({tag, "_pc"},    insn_pc_out,             pc);
    check_eq({tag, "_insn"},  insn_out,                mem_word(pc));
  endtask

  task automatic expect_bubble(input string tag);
    check_eq({tag, "_valid"}, {31'd0, insn_valid_out}, 32'd0);
    check_eq({tag, "_insn"},  insn_out,                32'h0000_0000);
  endtask

  task automatic expect_bus(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, "_req"}, {31'd0, imem_req_out}, {31'd0, req});
    if (req) begin
      check_eq({tag, "_addr"}, imem_addr_out, addr);
    end
  endtask

  task automatic expect_lvl(input string tag, input int lvl);
    check_eq({tag, "_lvl"}, {29'd0, fifo_level_out}, 32'(lvl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks           = 0;
    errors           = 0;
    clk_in           = 1'b0;
    reset_in         = 1'b0;
    imem_ack_in      = 1'b1;
    stall_in         = 1'b0;
    redirect_in      = 1'b0;
    redirect_addr_in = 32'h0;

    // Reset state, then streaming with ack held high
    @(negedge clk_in);
    check_reset("rst");
    reset_in = 1'b1;
    @(negedge clk_in);
    expect_bus("e1", 1'b1, 32'h0);
    expect_bubble("e1");
    @(negedge clk_in);
    expect_bus("e2", 1'b1, 32'h4);
    expect_lvl("e2", 1);
    expect_bubble("e2");
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk_in);
      expect_insn("stream", 32'(4 * (k - 3)));
      expect_bus("stream", 1'b1, 32'(4 * (k - 1)));
    end

    // Stall for six cycles: FIFO fills to 4, request drops, outputs hold
    stall_in = 1'b1;
    repeat (6) @(negedge clk_in);
    expect_lvl("stall_full", 4);
    expect_bus("stall_full", 1'b0, 32'h0);
    expect_insn("stall_hold", 32'h8);
    stall_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      expect_insn("drain", 32'(12 + 4 * i));
    end
    expect_bus("drain_end", 1'b1, 32'd40);
    expect_lvl("drain_end", 3);

    // Asynchronous reset mid-burst
    reset_in = 1'b0;
    #1;
    check_reset("rst_mid");

    // Ack delayed: request and address held for several cycles
    @(negedge clk_in);
    imem_ack_in = 1'b0;
    reset_in    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      expect_bus("ack_wait", 1'b1, 32'h0);
      expect_bubble("ack_wait");
    end
    imem_ack_in = 1'b1;
    @(negedge clk_in);
    expect_bus("ack_e5", 1'b1, 32'h4);
    expect_lvl("ack_e5", 1);
    expect_bubble("ack_e5");
    @(negedge clk_in);
    expect_insn("ack_e6", 32'h0);
    @(negedge clk_in);
    expect_insn("ack_e7", 32'h4);
    imem_ack_in = 1'b0;
    @(negedge clk_in);
    expect_insn("ack_e8", 32'h8);
    expect_bus("ack_e8", 1'b1, 32'hC);
    expect_lvl("ack_e8", 0);

    // Redirect while a request is pending without ack: drain, then fetch target
    redirect_in      = 1'b1;
    redirect_addr_in = 32'h0000_0103;
    @(negedge clk_in);
    expect_bubble("rd_e9");
    expect_bus("rd_e9", 1'b1, 32'hC);
    expect_lvl("rd_e9", 0);
    redirect_in = 1'b0;
    imem_ack_in = 1'b1;
    @(negedge clk_in);
    expect_bus("rd_e10", 1'b1, 32'h100);
    expect_lvl("rd_e10", 0);
    expect_bubble("rd_e10");
    @(negedge clk_in);
    expect_lvl("rd_e11", 1);
    expect_bubble("rd_e11");
    @(negedge clk_in);
    expect_insn("rd_e12", 32'h100);
    expect_bus("rd_e12", 1'b1, 32'h108);

    // Redirect with stall held and FIFO full: flush and resume at target
    stall_in = 1'b1;
    repeat (3) @(negedge clk_in);
    expect_lvl("sf_full", 4);
    expect_bus("sf_full", 1'b0, 32'h0);
    expect_insn("sf_hold", 32'h100);
    redirect_in      = 1'b1;
    redirect_addr_in = 32'h0000_0200;
    @(negedge clk_in);
    expect_bubble("sf_flush");
    expect_lvl("sf_flush", 0);
    expect_bus("sf_flush", 1'b1, 32'h200);
    redirect_in = 1'b0;
    stall_in    = 1'b0;
    @(negedge clk_in);
    expect_lvl("sf_e17", 1);
    expect_bus("sf_e17", 1'b1, 32'h204);
    @(negedge clk_in);
    expect_insn("sf_e18", 32'h200);

    // Redirect coinciding with ack, target near the top of the address space
    redirect_in      = 1'b1;
    redirect_addr_in = 32'hFFFF_FFF8;
    @(negedge clk_in);
    expect_bus("wr_e19", 1'b1, 32'hFFFF_FFF8);
    expect_lvl("wr_e19", 0);
    expect_bubble("wr_e19");
    redirect_in = 1'b0;
    @(negedge clk_in);
    expect_bus("wr_e20", 1'b1, 32'hFFFF_FFFC);
    @(negedge clk_in);
    expect_bus("wr_e21", 1'b1, 32'h0000_0000);
    expect_insn("wr_e21", 32'hFFFF_FFF8);
    @(negedge clk_in);
    expect_bus("wr_e22", 1'b1, 32'h0000_0004);
    expect_insn("wr_e22", 32'hFFFF_FFFC);
    @(negedge clk_in);
    expect_insn("wr_e23", 32'h0000_0000);

    // Reset mid-burst returns everything immediately
    reset_in = 1'b0;
    #1;
    check_reset("rst_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer_32.md
Name: fetch_sequencer_32

Overview:
- Instruction fetch controller that sequences the decode_32 unit.
- Issues instruction-memory requests with a req/ack handshake and buffers returned words with their PC in a small FIFO.
- Presents one instruction per clock to decode_32 on insn_in and insn_pc_in, honouring decode stall.
- Flushes and restarts on branch/jump redirects resolved downstream.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: entries of {pc, insn}. Power of 2, minimum 2.
- INSN_STEP, 4: PC increment per fetched word.

Ports:
- clk_in  input  1  system clock; all state updates on posedge.
- reset_in  input  1  asynchronous, active-low reset.
- imem_req_out  output  1  fetch request to instruction memory.
- imem_addr_out  output  32  fetch address; bits [1:0] always 0.
- imem_ack_in  input  1  memory accepts the request; imem_data_in is valid in the same cycle.
- imem_data_in  input  32  fetched instruction word.
- stall_in  input  1  decode/pipeline stall (from decode_32 stall_out); holds the decode-side outputs.
- redirect_in  input  1  single-cycle pulse: PC change taken (relative or absolute, resolved downstream).
- redirect_addr_in  input  32  redirect target; bits [1:0] ignored (treated as 0).
- insn_out  output  32  instruction to decode_32 insn_in.
- insn_pc_out  output  32  PC of insn_out, to decode_32 insn_pc_in.
- insn_valid_out  output  1  insn_out holds a real fetched instruction.
- fifo_level_out  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy (debug).

Behaviour:
- Reset (reset_in=0, async):
  - State S_IDLE. fetch_pc=RESET_PC. FIFO empty.
  - imem_req_out=0, imem_addr_out=RESET_PC.
  - insn_out=INSN_NOP (32'h0), insn_pc_out=0, insn_valid_out=0, fifo_level_out=0.
- Handshake rules:
  - imem_req_out and imem_addr_out are registered.
  - Once req is high, req and addr stay constant until a cycle with imem_ack_in=1. Req is never withdrawn early.
  - At most one request is outstanding.
  - imem_ack_in while req=0 is ignored.
- Space rule: a new request may be issued only if (fifo_level + outstanding) < FIFO_DEPTH.
- S_IDLE:
  - Space available → go to S_REQ, assert req with addr=fetch_pc at the next edge.
- S_REQ:
  - On ack, push {fetch_pc, imem_data_in} and set fetch_pc += INSN_STEP.
  - If space remains after the push, stay in S_REQ with req=1 and the new address in the next cycle (back-to-back fetch). Otherwise go to S_IDLE with req=0.
- S_DRAIN (entered on redirect while a request is pending with no ack that cycle):
  - Keep req/addr unchanged until ack. Discard the returned data.
  - Then set addr=redirect target and go to S_REQ.
  - A second redirect during S_DRAIN overwrites the pending target.
- Decode side, evaluated each posedge:
  - stall_in=1: insn_out, insn_pc_out and insn_valid_out hold. No pop.
  - stall_in=0 and FIFO non-empty: pop the head into the outputs, valid=1.
  - stall_in=0 and FIFO empty: insn_out=INSN_NOP, valid=0, insn_pc_out holds its previous value.
- Redirect, with priority over everything:
  - In the cycle after redirect_in: FIFO empty, insn_valid_out=0, insn_out=INSN_NOP. This applies even if stall_in=1.
  - fetch_pc = {redirect_addr_in[31:2], 2'b00}.
  - An ack in the same cycle as redirect is accepted on the bus but its data is discarded; the next request uses the target.
  - If no request is pending, the next request uses the target directly.
- Simultaneous push and pop: both occur and the level is unchanged. A push into a full FIFO cannot occur because of the space rule.
- Arithmetic: fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0). FIFO pointers wrap modulo FIFO_DEPTH.
- Latency: with ack at first request, first valid insn_out appears 3 edges after reset release (edge1 req, edge2 push, edge3 pop). Steady state with ack held high gives 1 instruction/cycle.
- Reset mid-operation: async return to reset values. Any in-flight memory response is not tracked. The memory must tolerate req dropping under reset.

Decomposition:
- Package fusion_fetch_pkg:
  - INSN_NOP = 32'h0000_0000.
  - State encodings S_IDLE, S_REQ, S_DRAIN.
  - Width constant for the fifo entry (64 bits: pc, insn).
- Sub-module fetch_fifo: FIFO_DEPTH x 64 synchronous FIFO with push, pop, flush, level, full, empty. Async active-low reset. Flush has priority over push and pop.

Test Plan:
- Reset release with ack tied 1 and stall 0 → imem_addr 0,4,8,… on consecutive cycles. insn_out tracks memory 1/cycle. insn_pc_out lags imem_addr by 2 cycles. First valid on edge 3.
- stall_in=1 for 6 cycles, ack=1 → FIFO fills to 4 and req drops. Outputs hold. fifo_level_out=4. On release, 4 buffered words drain in order with PCs 4 apart.
- Ack delayed 3 cycles → req and addr held constant for 3 cycles. insn_valid_out=0 while empty. No duplicate or skipped PC.
- redirect_in to 32'h0000_0103 while a request is pending without ack → S_DRAIN, old data discarded, next addr=32'h0000_0100. Valid=0 the following cycle. Next valid insn_pc_out=32'h100.
- Redirect with stall_in=1 and FIFO full → FIFO flushed, valid=0 despite stall. Fetch resumes at the target.
- Redirect to 32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Asserting reset mid-burst returns all outputs to reset values immediately.
